// File: rtl/dmem_stream_ctrl_pkg.sv
// dmem_stream_ctrl_pkg: shared geometry, FSM encoding and SRAM strobe level
// for the dmem stream controller.
package dmem_stream_ctrl_pkg;
    localparam int DM_ADDR = 4;
    localparam int DM_COLS = 64;
    localparam logic STROBE_OFF = 1'b1;
    typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_t;
endpackage

// File: rtl/dmem_skid_fifo.sv
// dmem_skid_fifo: two-entry FIFO catching dmem read data (data plus last tag)
// so the output stream can stall without losing in-flight reads.
module dmem_skid_fifo
    import dmem_stream_ctrl_pkg::*;
#(
    parameter int W = DM_COLS + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic wp, rp;

    assign head = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp <= !wp;
            end
            if (pop) rp <= !rp;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/dmem_stream_ctrl.sv
// dmem_stream_ctrl: fills dmem from an input stream through port 1, then drains
// it through port 2 (bit-reversed or natural order) onto an output stream.
module dmem_stream_ctrl
    import dmem_stream_ctrl_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR,
    parameter int DATA_W = DM_COLS,
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              WEB1,
    output logic              OEB1,
    output logic              CSB1,
    output logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] I1,
    output logic              WEB2,
    output logic              OEB2,
    output logic              CSB2,
    output logic [ADDR_W-1:0] A2,
    input  logic [DATA_W-1:0] O2
);
    state_t state;
    logic [ADDR_W-1:0] wr_cnt, rd_addr;
    logic [ADDR_W:0] rd_cnt;
    logic rd_last, fire_in, pop, issue;
    logic [1:0] occ;
    logic [DATA_W:0] head;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = x[ADDR_W-1-i];
        return r;
    endfunction

    assign fire_in = in_valid && in_ready;
    assign out_valid = occ != 2'd0;
    assign out_data = head[DATA_W-1:0];
    assign out_last = out_valid && head[DATA_W];
    assign pop = out_valid && out_ready;
    assign rd_addr = BITREV ? bitrev(rd_cnt[ADDR_W-1:0]) : rd_cnt[ADDR_W-1:0];
    // a pop this cycle frees the slot the newly issued read will land in
    assign issue = state == ST_DRAIN && !rd_cnt[ADDR_W]
                   && ({1'b0, occ} + 3'(!CSB2)) < (3'd2 + 3'(pop));
    assign OEB1 = STROBE_OFF;
    assign WEB2 = STROBE_OFF;
    assign busy = state == ST_FILL || state == ST_DRAIN;

    dmem_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (!CSB2),
        .push_data ({rd_last, O2}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
            rd_last <= 1'b0;
            in_ready <= 1'b0;
            WEB1 <= STROBE_OFF;
            CSB1 <= STROBE_OFF;
            A1 <= '0;
            I1 <= '0;
            CSB2 <= STROBE_OFF;
            OEB2 <= STROBE_OFF;
            A2 <= '0;
        end else begin
            CSB1 <= !fire_in;
            WEB1 <= !fire_in;
            CSB2 <= !issue;
            OEB2 <= !issue;
            if (fire_in) begin
                A1 <= wr_cnt;
                I1 <= in_data;
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (issue) begin
                A2 <= rd_addr;
                rd_cnt <= rd_cnt + 1'b1;
                rd_last <= &rd_cnt[ADDR_W-1:0];
            end
            if (state == ST_FILL && fire_in && &wr_cnt) begin
                state <= ST_DRAIN;
                in_ready <= 1'b0;
            end else if (state == ST_DRAIN && pop && head[DATA_W]) begin
                state <= ST_FILL;
                in_ready <= 1'b1;
                rd_cnt <= '0;
            end else begin
                in_ready <= state == ST_FILL;
            end
        end
    end
endmodule

// File: tb/tb_dmem_stream_ctrl.sv
// tb_dmem_stream_ctrl: directed frames through a bit-reversing and a natural-order
// controller, each attached to its own behavioural dmem.
module tb_dmem_stream_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, WEB1, OEB1, CSB1, WEB2, OEB2, CSB2;
    logic in_ready_n, out_valid_n, out_last_n, busy_n, WEB1_n, OEB1_n, CSB1_n, WEB2_n, OEB2_n, CSB2_n;
    logic [3:0] A1, A2, A1_n, A2_n;
    logic [63:0] out_data, I1, O2, out_data_n, I1_n, O2_n;
    logic [63:0] mem_b [16];
    logic [63:0] mem_n [16];
    int errs = 0, checks = 0, cyc = 0;
    int br16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    dmem_stream_ctrl #(.ADDR_W(4), .DATA_W(64), .BITREV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .WEB1(WEB1), .OEB1(OEB1), .CSB1(CSB1), .A1(A1), .I1(I1),
        .WEB2(WEB2), .OEB2(OEB2), .CSB2(CSB2), .A2(A2), .O2(O2)
    );

    dmem_stream_ctrl #(.ADDR_W(4), .DATA_W(64), .BITREV(1'b0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_last(out_last_n),
        .busy(busy_n), .WEB1(WEB1_n), .OEB1(OEB1_n), .CSB1(CSB1_n), .A1(A1_n), .I1(I1_n),
        .WEB2(WEB2_n), .OEB2(OEB2_n), .CSB2(CSB2_n), .A2(A2_n), .O2(O2_n)
    );

    always @(posedge clk) begin
        if (!CSB1 && !WEB1) mem_b[A1] <= I1;
        if (!CSB1_n && !WEB1_n) mem_n[A1_n] <= I1_n;
        cyc <= cyc + 1;
    end
    assign O2 = mem_b[A2];
    assign O2_n = mem_n[A2_n];

    int acc_c [$];
    int pop_c [$];
    logic [67:0] wr_q [$];
    logic [64:0] pop_b [$];
    logic [64:0] pop_nq [$];
    logic rdy_hist [4096];
    int first_rd = -1, iss_b = 0, iss_n = 0, npop_b = 0, npop_n = 0, max_out = 0;
    int stall_viol = 0, strobe_viol = 0;
    logic sp_b = 1'b0, sp_n = 1'b0;
    logic [63:0] sd_b = '0, sd_n = '0;

    always @(negedge clk) begin
        rdy_hist[cyc % 4096] = in_ready;
        if (in_valid && in_ready) acc_c.push_back(cyc);
        if (CSB1 != WEB1 || CSB2 != OEB2) strobe_viol++;
        if (!CSB1 && !WEB1) wr_q.push_back({A1, I1});
        if (!CSB2 && first_rd < 0) first_rd = cyc;
        if (out_valid && out_ready) begin
            pop_b.push_back({out_last, out_data});
            pop_c.push_back(cyc);
        end
        if (out_valid_n && out_ready) pop_nq.push_back({out_last_n, out_data_n});
        if (sp_b && (!out_valid || out_data != sd_b)) stall_viol++;
        if (sp_n && (!out_valid_n || out_data_n != sd_n)) stall_viol++;
        sp_b = out_valid && !out_ready;
        sp_n = out_valid_n && !out_ready;
        sd_b = out_data;
        sd_n = out_data_n;
        if (!rst_n) begin
            iss_b = 0; iss_n = 0; npop_b = 0; npop_n = 0;
        end else begin
            iss_b += int'(!CSB2);
            iss_n += int'(!CSB2_n);
            if (iss_b - npop_b > max_out) max_out = iss_b - npop_b;
            if (iss_n - npop_n > max_out) max_out = iss_n - npop_n;
            npop_b += int'(out_valid && out_ready);
            npop_n += int'(out_valid_n && out_ready);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        acc_c.delete(); pop_c.delete(); wr_q.delete(); pop_b.delete(); pop_nq.delete();
        first_rd = -1;
    endtask

    task automatic send_frame(input logic [63:0] base, input bit gaps);
        int n = 0;
        bit on = 1'b1, took;
        for (int t = 0; t < 400 && n < 16; t++) begin
            in_valid = on;
            in_data = base + 64'(n);
            took = on && in_ready;
            @(posedge clk); #1;
            if (took) n++;
            if (gaps) on = !on;
        end
        in_valid = 1'b0;
        chk("accepted", 64'(n), 64'd16);
    endtask

    task automatic wait_pops(input int n, input bit stall);
        logic [3:0] pat = 4'b1001;
        for (int t = 0; t < 300 && pop_b.size() < n; t++) begin
            out_ready = stall ? pat[t % 4] : 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("pops", 64'(pop_b.size()), 64'(n));
    endtask

    task automatic check_frame(input string f, input logic [63:0] base, input bit timed);
        chk({f, "_wr_count"}, 64'(wr_q.size()), 64'd16);
        chk({f, "_nat_count"}, 64'(pop_nq.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_q.size())
                chk($sformatf("%s_wr%0d", f, i), 64'(wr_q[i]), 64'({4'(i), base + 64'(i)}));
            if (i < pop_b.size())
                chk($sformatf("%s_br%0d", f, i), 64'(pop_b[i][63:0]), base + 64'(br16[i]));
            if (i < pop_b.size())
                chk($sformatf("%s_brlast%0d", f, i), 64'(pop_b[i][64]), 64'(i == 15));
            if (i < pop_nq.size())
                chk($sformatf("%s_nat%0d", f, i), 64'(pop_nq[i]), 64'({i == 15, base + 64'(i)}));
        end
        if (acc_c.size() >= 16) begin
            chk({f, "_drain_start"}, 64'(first_rd - acc_c[15]), 64'd2);
            if (timed && pop_c.size() >= 16) begin
                chk({f, "_latency"}, 64'(pop_c[0] - acc_c[15]), 64'd3);
                chk({f, "_rate"}, 64'(pop_c[15] - pop_c[0]), 64'd15);
            end
        end
    endtask

    initial begin
        int lp, a15, cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_strobes", 64'({WEB1, OEB1, CSB1, WEB2, OEB2, CSB2}), 64'h3f);
        chk("rst_addr", 64'({A1, A2}), 64'd0);
        chk("rst_i1", I1, 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_strobes", 64'({WEB1, OEB1, CSB1, WEB2, OEB2, CSB2}), 64'h3f);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd1);

        clr(); send_frame(64'h0, 1'b0); wait_pops(16, 1'b0); check_frame("A", 64'h0, 1'b1);
        clr(); send_frame(64'h20, 1'b0); wait_pops(16, 1'b1); check_frame("B", 64'h20, 1'b0);
        clr(); send_frame(64'h40, 1'b1); wait_pops(16, 1'b0); check_frame("C", 64'h40, 1'b1);

        clr(); send_frame(64'h60, 1'b0); wait_pops(7, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_strobes", 64'({WEB1, OEB1, CSB1, WEB2, OEB2, CSB2}), 64'h3f);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        clr(); send_frame(64'd100, 1'b0); wait_pops(16, 1'b0); check_frame("D", 64'd100, 1'b1);
        lp = pop_c.size() >= 16 ? pop_c[15] : 0;
        a15 = acc_c.size() >= 16 ? acc_c[15] : 0;
        cnt = 0;
        for (int c = a15 + 1; c <= lp; c++) cnt += int'(rdy_hist[c % 4096]);
        chk("D_ready_in_drain", 64'(cnt), 64'd0);

        clr(); send_frame(64'h80, 1'b0);
        chk("E_ready_after_last", 64'(rdy_hist[(lp + 1) % 4096]), 64'd1);
        chk("E_b2b_first_acc", 64'(acc_c.size() > 0 ? acc_c[0] : -1), 64'(lp + 1));
        wait_pops(16, 1'b0); check_frame("E", 64'h80, 1'b1);

        chk("strobe_pairs", 64'(strobe_viol), 64'd0);
        chk("stall_hold", 64'(stall_viol), 64'd0);
        chk("max_outstanding", 64'(max_out), 64'd2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
